// File: rtl/qmac_readout_if.sv
// Output channel of qmac_readout toward the activation stage.
// The master holds out_data/out_sat stable while out_valid is high. A word
// transfers on a rising edge where out_valid && out_ready are both high.
interface qmac_readout_if #(
    parameter int N = 8
);
    logic [N-1:0] out_data;
    logic         out_sat;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_sat,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_sat,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/qmac_readout.sv
// Reads the MAC accumulator back out after a counted dot-product window.
// The block requantizes the 2N-bit sign-magnitude value to N bits with round-half-up and saturation.
module qmac_readout #(
    parameter int Q  = 5,
    parameter int N  = 8,
    parameter int LW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [LW-1:0]   len,
    input  logic            step,
    input  logic [2*N-1:0]  acc_in,
    input  logic            acc_ovf,
    output logic            mac_clear,
    output logic            busy,
    output logic [2:0]      state_dbg,
    qmac_readout_if.master  out_if
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    localparam logic [2*N-1:0] RND  = (2*N)'(1 << (Q-1));
    localparam logic [2*N-1:0] MAXV = (2*N)'((1 << (N-1)) - 1);

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    data_q, data_d;
    logic            sat_q, sat_d;

    logic [LW:0]     cnt_inc;
    logic [2*N-1:0]  r_sum;
    logic [2*N-1:0]  r_mag;
    logic [N-2:0]    q_mag;
    logic            q_sat;
    logic            q_sign;

    // The MSB is the sign, so the magnitude-plus-half sum cannot carry out of 2N bits.
    always_comb begin
        r_sum  = {1'b0, acc_in[2*N-2:0]} + RND;
        r_mag  = r_sum >> Q;
        q_sat  = 1'b0;
        q_mag  = r_mag[N-2:0];
        if (r_mag > MAXV) begin
            q_mag = MAXV[N-2:0];
            q_sat = 1'b1;
        end
        q_sign = acc_in[2*N-1] & (q_mag != '0);
    end

    assign cnt_inc = {1'b0, cnt_q} + {{LW{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        sat_d   = sat_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = (len_q == '0) ? S_SETTLE : S_RUN;
            end
            S_RUN: begin
                if (step) begin
                    cnt_d = cnt_inc[LW-1:0];
                    ovf_d = ovf_q | acc_ovf;
                    if (cnt_inc == {1'b0, len_q}) state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                data_d  = {q_sign, q_mag};
                sat_d   = q_sat | ovf_q;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_if.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign mac_clear        = (state_q == S_CLEAR);
    assign busy             = (state_q != S_IDLE);
    assign state_dbg        = state_q;
    assign out_if.out_valid = (state_q == S_OUT);
    assign out_if.out_data  = data_q;
    assign out_if.out_sat   = sat_q;
endmodule

// File: tb/tb_qmac_readout.sv
// Bench for qmac_readout: directed windows, backpressure, reset, random accumulators.
// Expected {sat,data} words are queued at start and popped on output transfer.
module tb_qmac_readout;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        step;
    logic [15:0] acc_in;
    logic        acc_ovf;
    logic        mac_clear;
    logic        busy;
    logic [2:0]  state_dbg;

    logic [8:0]  exp_q[$];
    int          pass_cnt = 0;
    int          check_cnt = 0;

    qmac_readout_if #(.N(8)) out_if ();

    qmac_readout #(.Q(5), .N(8), .LW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .step      (step),
        .acc_in    (acc_in),
        .acc_ovf   (acc_ovf),
        .mac_clear (mac_clear),
        .busy      (busy),
        .state_dbg (state_dbg),
        .out_if    (out_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic logic [8:0] model(input logic [15:0] a, input logic ovf);
        int  mag;
        int  r;
        logic sat;
        logic sgn;
        logic [31:0] rv;
        mag = int'(a[14:0]);
        r   = (mag + 16) / 32;
        sat = 1'b0;
        if (r > 127) begin
            r   = 127;
            sat = 1'b1;
        end
        sgn = a[15] && (r != 0);
        rv  = 32'(r);
        return {sat | ovf, sgn, rv[6:0]};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; len = '0; step = 1'b0; acc_in = '0; acc_ovf = 1'b0;
        out_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({mac_clear, busy, out_if.out_valid, out_if.out_sat, out_if.out_data} !== 12'h000)
            $display("FAIL reset_outputs: got %h, required 000",
                     {mac_clear, busy, out_if.out_valid, out_if.out_sat, out_if.out_data});
        else pass_cnt++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Must be called at a negedge while the DUT is idle; returns at the negedge after the transfer.
    task automatic run_window(input int l, input int ovf_idx, input logic [15:0] fin,
                              input logic [8:0] exp, input int hold);
        logic [8:0] held;
        logic [8:0] got;
        int waited;
        start = 1'b1; len = 8'(l);
        @(negedge clk);
        start = 1'b0;
        check_cnt++;
        if (mac_clear !== 1'b1) $display("FAIL clear_pulse: got %b, required 1", mac_clear);
        else pass_cnt++;
        exp_q.push_back(exp);
        if (l == 0) acc_in = fin;
        @(negedge clk);
        check_cnt++;
        if (mac_clear !== 1'b0) $display("FAIL clear_single: got %b, required 0", mac_clear);
        else pass_cnt++;
        for (int i = 0; i < l; i++) begin
            step = 1'b1;
            acc_ovf = (i == ovf_idx);
            @(negedge clk);
        end
        step = 1'b0; acc_ovf = 1'b0; acc_in = fin;
        check_cnt++;
        if (out_if.out_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL settle: got valid=%b busy=%b, required valid=0 busy=1",
                     out_if.out_valid, busy);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (out_if.out_valid !== 1'b1) $display("FAIL latency: got valid=%b, required 1", out_if.out_valid);
        else pass_cnt++;
        waited = 0;
        while (out_if.out_valid !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (out_if.out_valid !== 1'b1) begin
            check_cnt++;
            $display("FAIL out_timeout: got no valid, required valid within 10 cycles");
            void'(exp_q.pop_front());
            return;
        end
        held = {out_if.out_sat, out_if.out_data};
        for (int h = 0; h < hold; h++) begin
            start = 1'b1;
            @(negedge clk);
            check_cnt++;
            if (out_if.out_valid !== 1'b1 || {out_if.out_sat, out_if.out_data} !== held || mac_clear !== 1'b0)
                $display("FAIL hold_stable: got valid=%b word=%h clear=%b, required valid=1 word=%h clear=0",
                         out_if.out_valid, {out_if.out_sat, out_if.out_data}, mac_clear, held);
            else pass_cnt++;
        end
        start = 1'b0;
        out_if.out_ready = 1'b1;
        got = {out_if.out_sat, out_if.out_data};
        check_cnt++;
        if (exp_q.size() == 0) $display("FAIL scoreboard_empty: got word %h, required queued entry", got);
        else begin
            held = exp_q.pop_front();
            if (got !== held) $display("FAIL result: got sat,data=%h, required %h", got, held);
            else pass_cnt++;
        end
        @(negedge clk);
        out_if.out_ready = 1'b0;
        check_cnt++;
        if (out_if.out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL after_xfer: got valid=%b busy=%b, required 0 0", out_if.out_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        run_window(1, -1, 16'h0400, 9'h020, 0);
        run_window(2, -1, 16'h8400, 9'h0A0, 0);
    endtask

    task automatic test_rounding();
        run_window(1, -1, 16'h0010, 9'h001, 0);
        run_window(1, -1, 16'h000F, 9'h000, 0);
        run_window(1, -1, 16'h800F, 9'h000, 0);
    endtask

    task automatic test_saturation();
        run_window(1, -1, 16'h3F01, 9'h17F, 0);
        run_window(2, -1, 16'hBF01, 9'h1FF, 0);
    endtask

    task automatic test_overflow();
        run_window(3, 1, 16'h0400, 9'h120, 0);
    endtask

    task automatic test_len_zero();
        run_window(0, -1, 16'h0000, 9'h000, 0);
    endtask

    task automatic test_back_to_back();
        run_window(1, -1, 16'h8010, 9'h081, 5);
        run_window(2, -1, 16'h0C00, 9'h060, 0);
    endtask

    task automatic test_random();
        logic [15:0] a;
        int l;
        int oi;
        for (int k = 0; k < 6; k++) begin
            a  = 16'($urandom_range(0, 65535));
            l  = $urandom_range(1, 4);
            oi = $urandom_range(0, 7);
            run_window(l, oi, a, model(a, oi < l), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        start = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_cnt++;
        if ({mac_clear, busy, out_if.out_valid, out_if.out_sat, out_if.out_data} !== 12'h000)
            $display("FAIL reset_mid_run: got %h, required 000",
                     {mac_clear, busy, out_if.out_valid, out_if.out_sat, out_if.out_data});
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step = 1'b1;
            @(negedge clk);
            if (out_if.out_valid === 1'b1 || busy === 1'b1) seen++;
        end
        step = 1'b0;
        check_cnt++;
        if (seen != 0) $display("FAIL abandon_window: got %0d active cycles, required 0", seen);
        else pass_cnt++;
        check_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_left: got %0d entries, required 0", exp_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_overflow();
        test_len_zero();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
